// File: rtl/playseq_uc.sv
// Control unit for the memory-sequence game: show a growing sequence, then check plays.
// Optional play timer path enabled by defining PLAYSEQ_UC_TIMEOUT_EN.
module playseq_uc (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       fimS,
    input  logic       enderecoIgualSequencia,
    input  logic       chavesIgualMemoria,
    input  logic       tem_jogada,
    input  logic       fimM,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraM,
    output logic       contaM,
    output logic       zeraT,
    output logic       contaT,
    output logic       mostra_leds,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

`ifdef PLAYSEQ_UC_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        MOSTRA_PROX = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        PROX_RODADA = 4'h8,
        GANHOU      = 4'hA,
        TIMEOUT     = 4'hD,
        PERDEU      = 4'hE
    } state_t;

    state_t state;
    state_t next;

    // State register; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= next;
        end
    end

    // Next-state selection and control decode of the current state.
    always_comb begin
        next        = state;
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraS       = 1'b0;
        contaS      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zeraM       = 1'b0;
        contaM      = 1'b0;
        zeraT       = 1'b0;
        contaT      = 1'b0;
        mostra_leds = 1'b0;
        ganhou      = 1'b0;
        perdeu      = 1'b0;
        timeout     = 1'b0;
        pronto      = 1'b0;
        unique case (state)
            INICIAL: begin
                if (jogar) begin
                    next = PREPARA;
                end
            end
            PREPARA: begin
                zeraE = 1'b1;
                zeraS = 1'b1;
                zeraR = 1'b1;
                zeraM = 1'b1;
                zeraT = TO_EN;
                next  = MOSTRA;
            end
            MOSTRA: begin
                mostra_leds = 1'b1;
                contaM      = 1'b1;
                if (fimM) begin
                    next = MOSTRA_PROX;
                end
            end
            MOSTRA_PROX: begin
                zeraM = 1'b1;
                // last item shown: rewind address for the play phase
                if (enderecoIgualSequencia) begin
                    zeraE = 1'b1;
                    zeraT = TO_EN;
                    next  = ESPERA;
                end else begin
                    contaE = 1'b1;
                    next   = MOSTRA;
                end
            end
            ESPERA: begin
                contaT = TO_EN;
                // a press in the same cycle as expiry still counts
                if (tem_jogada) begin
                    next = REGISTRA;
                end else if (fimT && TO_EN) begin
                    next = TIMEOUT;
                end
            end
            REGISTRA: begin
                registraR = 1'b1;
                zeraT     = TO_EN;
                next      = COMPARA;
            end
            COMPARA: begin
                if (!chavesIgualMemoria) begin
                    next = PERDEU;
                end else if (!enderecoIgualSequencia) begin
                    next = PROX_JOGADA;
                end else if (fimS) begin
                    next = GANHOU;
                end else begin
                    next = PROX_RODADA;
                end
            end
            PROX_JOGADA: begin
                contaE = 1'b1;
                next   = ESPERA;
            end
            PROX_RODADA: begin
                contaS = 1'b1;
                zeraE  = 1'b1;
                zeraM  = 1'b1;
                next   = MOSTRA;
            end
            GANHOU: begin
                ganhou = 1'b1;
                pronto = 1'b1;
                if (jogar) begin
                    next = PREPARA;
                end
            end
            PERDEU: begin
                perdeu = 1'b1;
                pronto = 1'b1;
                if (jogar) begin
                    next = PREPARA;
                end
            end
            TIMEOUT: begin
                timeout = TO_EN;
                pronto  = 1'b1;
                if (jogar) begin
                    next = PREPARA;
                end
            end
            default: begin
                next = INICIAL;
            end
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_playseq_uc.sv
// Bench for playseq_uc: game-level plan of expected states driven through a
// behavioural datapath (counters reacting to the control outputs).
module tb_playseq_uc;

`ifdef PLAYSEQ_UC_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, jogar, fimS, enderecoIgualSequencia;
    logic chavesIgualMemoria, tem_jogada, fimM, fimT;
    logic zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic zeraM, contaM, zeraT, contaT, mostra_leds;
    logic ganhou, perdeu, timeout, pronto;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] st;
        bit rst;
        bit jog;
        bit tem;
        bit chv;
        bit lst;
        int dm;
        int tlim;
        int nr;
    } ent_t;

    ent_t q[$];

    int cntE = 0;
    int cntS = 0;
    int cntM = 0;
    int cntT = 0;

    playseq_uc dut (
        .clock(clock),
        .reset(reset),
        .jogar(jogar),
        .fimS(fimS),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .chavesIgualMemoria(chavesIgualMemoria),
        .tem_jogada(tem_jogada),
        .fimM(fimM),
        .fimT(fimT),
        .zeraE(zeraE),
        .contaE(contaE),
        .zeraS(zeraS),
        .contaS(contaS),
        .zeraR(zeraR),
        .registraR(registraR),
        .zeraM(zeraM),
        .contaM(contaM),
        .zeraT(zeraT),
        .contaT(contaT),
        .mostra_leds(mostra_leds),
        .ganhou(ganhou),
        .perdeu(perdeu),
        .timeout(timeout),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Control outputs each state must show, straight from the state table.
    function automatic logic [14:0] exp_outs(logic [3:0] st, bit lst);
        logic zE, cE, zS, cS, zR, rR, zM, cM, zT, cT, ml, g, pe, to, pr;
        {zE, cE, zS, cS, zR, rR, zM, cM} = 8'h00;
        {zT, cT, ml, g, pe, to, pr} = 7'h00;
        case (st)
            4'h1: begin zE = 1; zS = 1; zR = 1; zM = 1; zT = TO; end
            4'h2: begin ml = 1; cM = 1; end
            4'h3: begin
                zM = 1;
                if (lst) begin zE = 1; zT = TO; end
                else cE = 1;
            end
            4'h4: cT = TO;
            4'h5: begin rR = 1; zT = TO; end
            4'h7: cE = 1;
            4'h8: begin cS = 1; zE = 1; zM = 1; end
            4'hA: begin g = 1; pr = 1; end
            4'hD: begin to = 1; pr = 1; end
            4'hE: begin pe = 1; pr = 1; end
            default: ;
        endcase
        return {zE, cE, zS, cS, zR, rR, zM, cM, zT, cT, ml, g, pe, to, pr};
    endfunction

    task automatic push(logic [3:0] st, bit rst, bit jog, bit tem, bit chv,
                        bit lst, int dm, int tlim, int nr);
        ent_t e;
        e.st = st; e.rst = rst; e.jog = jog; e.tem = tem; e.chv = chv;
        e.lst = lst; e.dm = dm; e.tlim = tlim; e.nr = nr;
        q.push_back(e);
    endtask

    task automatic term(logic [3:0] code, int hold, bit jend,
                        int dm, int tlim, int nr);
        for (int h = 0; h < hold; h++)
            push(code, 0, 0, rb(), rb(), 0, dm, tlim, nr);
        push(code, 0, jend, rb(), rb(), 0, dm, tlim, nr);
    endtask

    // Expected state trace of one whole game, starting in PREPARA.
    task automatic gen_game(int nr, int bad_r, int bad_p, int dm, int tlim,
                            int wmax, int to_r, int to_p, int hold, bit jend);
        int w;
        bit done;
        bit bad;
        done = 0;
        push(4'h1, 0, rb(), rb(), rb(), 0, dm, tlim, nr);
        for (int r = 0; r < nr && !done; r++) begin
            for (int a = 0; a <= r; a++) begin
                for (int k = 0; k <= dm; k++)
                    push(4'h2, 0, rb(), rb(), rb(), 0, dm, tlim, nr);
                push(4'h3, 0, rb(), rb(), rb(), a == r, dm, tlim, nr);
            end
            for (int p = 0; p <= r && !done; p++) begin
                if (r == to_r && p == to_p) w = tlim + 2;
                else w = $urandom_range(0, wmax);
                if (TO && w > tlim) begin
                    for (int i = 0; i <= tlim; i++)
                        push(4'h4, 0, rb(), 0, rb(), 0, dm, tlim, nr);
                    term(4'hD, hold, jend, dm, tlim, nr);
                    done = 1;
                end else begin
                    for (int i = 0; i < w; i++)
                        push(4'h4, 0, rb(), 0, rb(), 0, dm, tlim, nr);
                    push(4'h4, 0, rb(), 1, rb(), 0, dm, tlim, nr);
                    push(4'h5, 0, rb(), rb(), rb(), 0, dm, tlim, nr);
                    bad = (r == bad_r && p == bad_p);
                    push(4'h6, 0, rb(), rb(), !bad, 0, dm, tlim, nr);
                    if (bad) begin
                        term(4'hE, hold, jend, dm, tlim, nr);
                        done = 1;
                    end else if (p < r) begin
                        push(4'h7, 0, rb(), rb(), rb(), 0, dm, tlim, nr);
                    end else if (r == nr - 1) begin
                        term(4'hA, hold, jend, dm, tlim, nr);
                        done = 1;
                    end else begin
                        push(4'h8, 0, rb(), rb(), rb(), 0, dm, tlim, nr);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [14:0] obs;
        logic [14:0] expv;
        ent_t e;
        int ng;
        int nr;
        int br;

        reset = 1; jogar = 0; fimS = 0; enderecoIgualSequencia = 0;
        chavesIgualMemoria = 0; tem_jogada = 0; fimM = 0; fimT = 0;

        // reset dominates jogar, then a held jogar gives one PREPARA only
        push(4'h0, 1, 1, 0, 0, 0, 0, 1, 1);
        push(4'h0, 0, 0, 1, 1, 0, 0, 1, 1);
        push(4'h0, 0, 1, 0, 0, 0, 9, 1, 1);
        push(4'h1, 0, 1, 0, 0, 0, 9, 1, 1);
        for (int i = 0; i < 3; i++) push(4'h2, 0, 1, 0, 0, 0, 9, 1, 1);
        push(4'h2, 1, 1, 1, 1, 0, 9, 1, 1);
        push(4'h0, 0, 1, 0, 0, 0, 0, 3, 2);
        // two-round win, replay into a round-1 loss, then a timed-out play
        gen_game(2, -1, -1, 0, 3, 0, -1, -1, 2, 1);
        gen_game(1, 0, 0, 0, 3, 0, -1, -1, 1, 1);
        gen_game(1, -1, -1, 0, 1, 0, 0, 0, 2, 0);
        push(q[q.size()-1].st, 1, 1, 0, 0, 0, 0, 1, 1);
        // reset in the middle of the play phase
        push(4'h0, 0, 1, 0, 0, 0, 0, 1, 1);
        push(4'h1, 0, 0, 0, 0, 0, 0, 1, 1);
        push(4'h2, 0, 0, 0, 0, 0, 0, 1, 1);
        push(4'h3, 0, 0, 0, 0, 1, 0, 1, 1);
        push(4'h4, 1, 1, 1, 1, 0, 0, 1, 1);
        push(4'h0, 0, 1, 0, 0, 0, 0, 1, 1);
        ng = 25;
        for (int g = 0; g < ng; g++) begin
            nr = $urandom_range(1, 3);
            br = $urandom_range(0, 4);
            gen_game(nr, br, $urandom_range(0, br), $urandom_range(0, 2),
                     $urandom_range(1, 3), $urandom_range(0, 4), -1, -1,
                     $urandom_range(0, 2), g < ng - 1);
        end

        repeat (2) @(posedge clock);
        #1;

        for (int c = 0; c < q.size(); c++) begin
            e = q[c];
            reset = e.rst;
            jogar = e.jog;
            tem_jogada = e.tem;
            chavesIgualMemoria = e.chv;
            fimM = (cntM == e.dm);
            fimS = (cntS == e.nr - 1);
            enderecoIgualSequencia = (cntE == cntS);
            if (TO) fimT = (cntT == e.tlim);
            else fimT = rb();
            #1;
            vectors++;
            assert (db_estado === e.st) else begin
                miscompares++;
                $error("FAIL state c=%0d obs=%h exp=%h", c, db_estado, e.st);
            end
            obs = {zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraM,
                   contaM, zeraT, contaT, mostra_leds, ganhou, perdeu,
                   timeout, pronto};
            expv = exp_outs(e.st, e.lst);
            vectors++;
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL outs c=%0d st=%h obs=%b exp=%b",
                       c, e.st, obs, expv);
            end
            vectors++;
            assert (int'(ganhou) + int'(perdeu) + int'(timeout) <= 1) else begin
                miscompares++;
                $error("FAIL flags c=%0d obs=%b%b%b exp=onehot0",
                       c, ganhou, perdeu, timeout);
            end
            if (zeraE) cntE = 0; else if (contaE) cntE++;
            if (zeraS) cntS = 0; else if (contaS) cntS++;
            if (zeraM) cntM = 0; else if (contaM) cntM++;
            if (zeraT) cntT = 0; else if (contaT) cntT++;
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
